// File: rtl/ecc_sign_if.sv
// Request/response bundle between an ECDSA signer and its requester.
interface ecc_sign_if #(
    parameter int unsigned WIDTH = 256
);
    logic             in_valid;
    logic [WIDTH-1:0] hash;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] Rx;
    logic             out_valid;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] s;
    logic             fail;

    modport master (
        output in_valid, hash, d, k, Rx,
        input  out_valid, r, s, fail
    );

    modport slave (
        input  in_valid, hash, d, k, Rx,
        output out_valid, r, s, fail
    );
endinterface

// File: rtl/ecc_sign.sv
// ECDSA signer: r = Rx mod N, s = k^-1 * (hash + r*d) mod N, bit-serial datapath.
module ecc_sign #(
    parameter int unsigned      WIDTH = 256,
    parameter logic [WIDTH-1:0] N     = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141
) (
    input  logic       clk,
    input  logic       rst_n,
    ecc_sign_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH:0] NX = {1'b0, N};

    typedef enum logic [2:0] {
        IDLE, REDUCE, MUL_RD, ADD_H, INV_K, MUL_S, DONE
    } state_t;

    // One conditional subtract; inputs are below 2N.
    function automatic logic [WIDTH-1:0] red(input logic [WIDTH-1:0] x);
        return (x >= N) ? x - N : x;
    endfunction

    function automatic logic [WIDTH-1:0] add_m(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sm;
        sm = {1'b0, a} + {1'b0, b};
        return (sm >= NX) ? WIDTH'(sm - NX) : WIDTH'(sm);
    endfunction

    function automatic logic [WIDTH-1:0] sub_m(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a >= b) ? a - b : WIDTH'({1'b0, a} + NX - {1'b0, b});
    endfunction

    // x/2 mod N; odd x is lifted by N first, which needs the extra bit.
    function automatic logic [WIDTH-1:0] half_m(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] e;
        e = x[0] ? ({1'b0, x} + NX) : {1'b0, x};
        return WIDTH'(e >> 1);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hash_q, hash_d;   // raw, then reduced hash
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // multiplier accumulator, also holds t
    logic [WIDTH-1:0] ma_q, ma_d;       // multiplier bit source, consumed MSB-first
    logic [WIDTH-1:0] mb_q, mb_d;       // multiplicand
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] r_out_q, r_out_d, s_out_q, s_out_d;
    logic             fail_out_q, fail_out_d;

    logic [WIDTH-1:0] rx_red_c, k_red_c, dbl_c, mul_nxt_c;
    logic             early_fail_c, mul_last_c, inv_done_c;

    // Shared shift-add multiplier step and common status terms.
    always_comb begin
        rx_red_c     = red(rx_q);
        k_red_c      = red(k_q);
        early_fail_c = (rx_red_c == '0) || (k_red_c == '0);
        dbl_c        = add_m(acc_q, acc_q);
        mul_nxt_c    = ma_q[WIDTH-1] ? add_m(dbl_c, mb_q) : dbl_c;
        mul_last_c   = (cnt_q == CNT_W'(WIDTH - 1));
        inv_done_c   = (u_q == WIDTH'(1)) || (v_q == WIDTH'(1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = REDUCE;
            REDUCE:  state_d = early_fail_c ? DONE : MUL_RD;
            MUL_RD:  if (mul_last_c) state_d = ADD_H;
            ADD_H:   state_d = INV_K;
            INV_K:   if (inv_done_c) state_d = MUL_S;
            MUL_S:   if (mul_last_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output updates per state.
    always_comb begin
        hash_d = hash_q;  d_d = d_q;  k_d = k_q;  rx_d = rx_q;  r_d = r_q;
        acc_d  = acc_q;   ma_d = ma_q; mb_d = mb_q; cnt_d = cnt_q;
        u_d    = u_q;     v_d = v_q;   x1_d = x1_q; x2_d = x2_q;
        out_valid_d = 1'b0;
        r_out_d     = '0;
        s_out_d     = '0;
        fail_out_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    hash_d = bus.hash;
                    d_d    = bus.d;
                    k_d    = bus.k;
                    rx_d   = bus.Rx;
                end
            end
            REDUCE: begin
                hash_d = red(hash_q);
                r_d    = rx_red_c;
                acc_d  = '0;
                ma_d   = rx_red_c;
                mb_d   = red(d_q);
                cnt_d  = '0;
                u_d    = k_red_c;
                v_d    = N;
                x1_d   = WIDTH'(1);
                x2_d   = '0;
                if (early_fail_c) begin
                    out_valid_d = 1'b1;
                    fail_out_d  = 1'b1;
                end
            end
            MUL_RD: begin
                acc_d = mul_nxt_c;
                ma_d  = ma_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
            end
            ADD_H: begin
                acc_d = add_m(acc_q, hash_q);
            end
            INV_K: begin
                if (inv_done_c) begin
                    mb_d  = acc_q;
                    ma_d  = (u_q == WIDTH'(1)) ? x1_q : x2_q;
                    acc_d = '0;
                    cnt_d = '0;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_m(x1_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_m(x2_q);
                end else if (u_q >= v_q) begin
                    // Difference of two odds is even: halve in the same cycle.
                    u_d  = (u_q - v_q) >> 1;
                    x1_d = half_m(sub_m(x1_q, x2_q));
                end else begin
                    v_d  = (v_q - u_q) >> 1;
                    x2_d = half_m(sub_m(x2_q, x1_q));
                end
            end
            MUL_S: begin
                acc_d = mul_nxt_c;
                ma_d  = ma_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (mul_last_c) begin
                    out_valid_d = 1'b1;
                    if (mul_nxt_c == '0) begin
                        fail_out_d = 1'b1;
                    end else begin
                        r_out_d = r_q;
                        s_out_d = mul_nxt_c;
                    end
                end
            end
            DONE:    ;
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_q <= '0;  d_q <= '0;  k_q <= '0;  rx_q <= '0;  r_q <= '0;
            acc_q  <= '0;  ma_q <= '0; mb_q <= '0; cnt_q <= '0;
            u_q    <= '0;  v_q <= '0;  x1_q <= '0; x2_q <= '0;
            out_valid_q <= 1'b0;
            r_out_q     <= '0;
            s_out_q     <= '0;
            fail_out_q  <= 1'b0;
        end else begin
            hash_q <= hash_d;  d_q <= d_d;  k_q <= k_d;  rx_q <= rx_d;  r_q <= r_d;
            acc_q  <= acc_d;   ma_q <= ma_d; mb_q <= mb_d; cnt_q <= cnt_d;
            u_q    <= u_d;     v_q <= v_d;   x1_q <= x1_d; x2_q <= x2_d;
            out_valid_q <= out_valid_d;
            r_out_q     <= r_out_d;
            s_out_q     <= s_out_d;
            fail_out_q  <= fail_out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_out_q;
    assign bus.s         = s_out_q;
    assign bus.fail      = fail_out_q;

endmodule

// File: tb/tb_ecc_sign.sv
// Directed-table and sequence bench for ecc_sign.
module tb_ecc_sign;

    localparam logic [255:0] NN = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
    localparam logic [255:0] GX = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam int MAX_LAT = 1027;
    localparam int NVEC    = 10;

    typedef struct {
        logic [255:0] hash;
        logic [255:0] d;
        logic [255:0] k;
        logic [255:0] rx;
        logic [255:0] er;
        logic [255:0] es;
        logic         ef;
        int           elat;   // exact latency required, 0 = only the upper bound
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   zero_viol = 0;

    ecc_sign_if #(.WIDTH(256)) bus ();

    ecc_sign #(.WIDTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Outputs must be all-zero whenever out_valid is low.
    always @(negedge clk) begin
        if (!bus.out_valid && (bus.r != '0 || bus.s != '0 || bus.fail))
            zero_viol++;
    end

    function automatic logic [255:0] md(input logic [511:0] x);
        logic [511:0] q;
        q = x % {256'd0, NN};
        return 256'(q);
    endfunction

    function automatic logic [255:0] mulm(input logic [255:0] a, input logic [255:0] b);
        return md({256'd0, a} * {256'd0, b});
    endfunction

    function automatic logic [255:0] addm(input logic [255:0] a, input logic [255:0] b);
        return md({256'd0, a} + {256'd0, b});
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request at a negedge and wait (bounded) for its out_valid.
    task automatic run_vec(input logic [255:0] h, input logic [255:0] dd,
                           input logic [255:0] kk, input logic [255:0] rr,
                           output logic [255:0] ro, output logic [255:0] so,
                           output logic fo, output int lat, output bit got);
        bus.hash = h; bus.d = dd; bus.k = kk; bus.Rx = rr;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1; got = 1'b0; ro = '0; so = '0; fo = 1'b0;
        while (lat < 1200 && !got) begin
            if (bus.out_valid) begin
                got = 1'b1;
                ro = bus.r; so = bus.s; fo = bus.fail;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        @(negedge clk);
    endtask

    vec_t         tbl [NVEC];
    logic [255:0] r_o, s_o, inv3;
    logic [256:0] t3;
    logic         f_o;
    int           lat, ov;
    bit           got;

    initial begin
        t3   = ((NN % 256'd3) == 256'd1) ? ({1'b0, NN} * 257'd2 + 257'd1) : ({1'b0, NN} + 257'd1);
        inv3 = 256'(t3 / 257'd3);

        tbl[0] = '{hash: 256'd7,        d: 256'd0,        k: 256'd1,        rx: 256'd5,        er: 256'd5,  es: 256'd7,  ef: 1'b0, elat: 0};
        tbl[1] = '{hash: 256'd5,        d: 256'd1,        k: 256'd2,        rx: 256'd3,        er: 256'd3,  es: 256'd4,  ef: 1'b0, elat: 0};
        tbl[2] = '{hash: 256'd1,        d: 256'd0,        k: 256'd3,        rx: 256'd1,        er: 256'd1,  es: inv3,    ef: 1'b0, elat: 0};
        tbl[3] = '{hash: 256'd7,        d: 256'd1,        k: 256'd0,        rx: 256'd5,        er: 256'd0,  es: 256'd0,  ef: 1'b1, elat: 2};
        tbl[4] = '{hash: 256'd7,        d: 256'd1,        k: 256'd1,        rx: NN,            er: 256'd0,  es: 256'd0,  ef: 1'b1, elat: 2};
        tbl[5] = '{hash: NN - 256'd3,   d: 256'd1,        k: 256'd1,        rx: 256'd3,        er: 256'd0,  es: 256'd0,  ef: 1'b1, elat: 0};
        tbl[6] = '{hash: NN + 256'd7,   d: 256'd0,        k: NN + 256'd1,   rx: NN + 256'd5,   er: 256'd5,  es: 256'd7,  ef: 1'b0, elat: 0};
        tbl[7] = '{hash: 256'd0,        d: 256'd1,        k: 256'd1,        rx: GX,            er: GX,      es: GX,      ef: 1'b0, elat: 0};
        tbl[8] = '{hash: 256'd6,        d: NN,            k: 256'd2,        rx: 256'd4,        er: 256'd4,  es: 256'd3,  ef: 1'b0, elat: 0};
        tbl[9] = '{hash: 256'd1,        d: NN + 256'd2,   k: 256'd1,        rx: 256'd3,        er: 256'd3,  es: 256'd7,  ef: 1'b0, elat: 0};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.hash = '0; bus.d = '0; bus.k = '0; bus.Rx = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 256'(bus.out_valid), 256'd0);
        chk("rst_r", bus.r, 256'd0);
        chk("rst_s", bus.s, 256'd0);
        chk("rst_fail", 256'(bus.fail), 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < NVEC; i++) begin
            run_vec(tbl[i].hash, tbl[i].d, tbl[i].k, tbl[i].rx, r_o, s_o, f_o, lat, got);
            chk($sformatf("v%0d_got", i), 256'(got), 256'd1);
            chk($sformatf("v%0d_r", i), r_o, tbl[i].er);
            chk($sformatf("v%0d_s", i), s_o, tbl[i].es);
            chk($sformatf("v%0d_fail", i), 256'(f_o), 256'(tbl[i].ef));
            chk($sformatf("v%0d_lat_bound", i), 256'(lat <= MAX_LAT), 256'd1);
            if (tbl[i].elat != 0)
                chk($sformatf("v%0d_lat", i), 256'(lat), 256'(tbl[i].elat));
            if (!tbl[i].ef)
                chk($sformatf("v%0d_ident", i), mulm(s_o, md({256'd0, tbl[i].k})),
                    addm(md({256'd0, tbl[i].hash}), mulm(r_o, md({256'd0, tbl[i].d}))));
        end

        // Re-pulse 10 cycles into a computation: ignored, single result.
        bus.hash = 256'd5; bus.d = 256'd1; bus.k = 256'd2; bus.Rx = 256'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        ov = 0; r_o = '0; s_o = '0; f_o = 1'b1;
        for (int c = 1; c < 1100; c++) begin
            if (c == 10) begin
                bus.hash = 256'd99; bus.k = 256'd1; bus.Rx = 256'd9; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                if (ov == 0) begin r_o = bus.r; s_o = bus.s; f_o = bus.fail; end
                ov++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("repulse_count", 256'(ov), 256'd1);
        chk("repulse_r", r_o, 256'd3);
        chk("repulse_s", s_o, 256'd4);
        chk("repulse_fail", 256'(f_o), 256'd0);

        // Reset during the inverse phase aborts without a result.
        bus.hash = 256'd1; bus.d = 256'd0; bus.k = 256'd3; bus.Rx = 256'd1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 256'(bus.out_valid), 256'd0);
        chk("abort_r", bus.r, 256'd0);
        chk("abort_s", bus.s, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ov = 0;
        for (int c = 0; c < 1100; c++) begin
            if (bus.out_valid) ov++;
            @(negedge clk);
        end
        chk("abort_no_result", 256'(ov), 256'd0);
        run_vec(256'd5, 256'd1, 256'd2, 256'd3, r_o, s_o, f_o, lat, got);
        chk("post_rst_got", 256'(got), 256'd1);
        chk("post_rst_r", r_o, 256'd3);
        chk("post_rst_s", s_o, 256'd4);

        // Random vectors checked through the signing identity s*k = hash + r*d.
        for (int i = 0; i < 12; i++) begin
            logic [255:0] h, dd, kk, rr;
            for (int w = 0; w < 8; w++) begin
                h[w*32 +: 32]  = $urandom;
                dd[w*32 +: 32] = $urandom;
                kk[w*32 +: 32] = $urandom;
                rr[w*32 +: 32] = $urandom;
            end
            run_vec(h, dd, kk, rr, r_o, s_o, f_o, lat, got);
            chk($sformatf("rnd%0d_got", i), 256'(got), 256'd1);
            chk($sformatf("rnd%0d_lat", i), 256'(lat <= MAX_LAT), 256'd1);
            chk($sformatf("rnd%0d_fail", i), 256'(f_o), 256'd0);
            chk($sformatf("rnd%0d_r", i), r_o, md({256'd0, rr}));
            chk($sformatf("rnd%0d_ident", i), mulm(s_o, md({256'd0, kk})),
                addm(md({256'd0, h}), mulm(r_o, md({256'd0, dd}))));
        end

        chk("zero_when_idle", 256'(zero_viol), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_sign.md
Name: ecc_sign

Overview:
- ECDSA signature generator; the producer end of the (r, s, hash) interface consumed by ecc_verify.
- Takes a message hash, private key d, nonce k and the precomputed x-coordinate Rx of k·G.
- Computes r = Rx mod N and s = k⁻¹·(hash + r·d) mod N with iterative bit-serial modular arithmetic.
- Its r/s outputs feed the verifier's r/s inputs directly in system tests.

Parameters:
- WIDTH, 256, operand and result width in bits.
- N, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141, curve group order (secp256k1); odd, with 2^(WIDTH-1) < N < 2^WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  one-cycle request strobe; hash/d/k/Rx sampled in the same cycle.
- hash  input  WIDTH  message digest.
- d  input  WIDTH  private key.
- k  input  WIDTH  per-signature nonce.
- Rx  input  WIDTH  x-coordinate of k·G, produced upstream.
- out_valid  output  1  one-cycle result strobe.
- r  output  WIDTH  signature r; valid only while out_valid=1.
- s  output  WIDTH  signature s; valid only while out_valid=1.
- fail  output  1  degenerate signature flag; valid only while out_valid=1.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: out_valid=0, r=0, s=0, fail=0, FSM=IDLE, all datapath registers cleared.
- Reset mid-operation aborts the computation; no out_valid is produced for the aborted request.
- Outputs are 0 whenever out_valid=0.
- FSM states:
  - IDLE: in_valid=1 latches all inputs, go to REDUCE.
  - REDUCE (1 cycle): each of hash, d, k, Rx reduced by one conditional subtract of N, since each input < 2N. Then r_reg = Rx mod N. If r_reg==0 or k_red==0, go to DONE with fail=1; else go to MUL_RD.
  - MUL_RD (WIDTH cycles): t = r_reg·d_red mod N, MSB-first shift-add. Per cycle: acc = 2·acc mod N, then if bit set, acc = acc + b mod N. Every intermediate is held in WIDTH+1 bits with a conditional subtract of N.
  - ADD_H (1 cycle): t = (t + hash_red) mod N, WIDTH+1-bit sum with conditional subtract.
  - INV_K: kinv = k_red⁻¹ mod N by binary extended Euclid. Variables u=k_red, v=N, x1=1, x2=0. For halving an odd xi, use (xi+N)/2 with a WIDTH+1-bit intermediate. Loop ends when u==1 or v==1. Bound: ≤ 2·WIDTH iterations, one iteration per cycle.
  - MUL_S (WIDTH cycles): s_reg = kinv·t mod N, same multiplier as MUL_RD; the shared multiplier instance is required. If s_reg==0, fail=1.
  - DONE (1 cycle): out_valid=1. Drive r=r_reg and s=s_reg, or r=0, s=0, fail=1 on any failure. Return to IDLE.
- Latency, in_valid to out_valid: ≤ 1+WIDTH+1+2·WIDTH+WIDTH+1 = 4·WIDTH+3 cycles (1027 at WIDTH=256). Early fail exits after 2 cycles.
- in_valid while not IDLE is ignored; no queueing. in_valid in the DONE cycle is also ignored.
- d ≥ N is accepted and reduced; d_red==0 is legal and gives s = k⁻¹·hash.

Test Plan:
- Baseline: k=1, d=0, Rx=5, hash=7 -> out_valid pulse; r=5, s=7, fail=0.
- Inverse path: k=2, d=1, Rx=3, hash=5 -> r=3, s=4, fail=0. Also k=3, d=0, Rx=1, hash=1 -> s·3 mod N == 1 per the reference model.
- Degenerate cases:
  - k=0 -> fail=1, r=0, s=0, out_valid exactly 2 cycles after in_valid.
  - Rx=N -> same response as k=0.
  - k=1, d=1, Rx=3, hash=N-3 -> s=0, fail=1.
- Reduction: hash=N+7, k=N+1, d=0, Rx=N+5 -> r=5, s=7. Real vector: d=1, k=1, Rx=Gx, hash=0 -> r=s=Gx.
- Protocol:
  - in_valid re-pulsed 10 cycles into a computation -> ignored; exactly one out_valid.
  - Outputs are 0 every non-out_valid cycle.
  - Latency ≤ 1027 cycles over 200 random vectors, and each random pair (r, s) is accepted by ecc_verify with fail=0.
- Reset: rst_n low for 1 cycle during INV_K -> outputs 0 immediately and no out_valid. The next request completes correctly.
